// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types, defaults and address-decode helpers for the
//               byte-enabled data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    localparam logic [31:0] DEFAULT_FAULT_DATA = 32'hfa11_1eaf;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACC_OK         = 2'd0,
        ACC_MISALIGNED = 2'd1,
        ACC_RANGE      = 2'd2
    } acc_status_t;

    // The window end is formed in 33 bits so a window at the top of the
    // address space does not wrap back to zero.
    function automatic acc_status_t addr_ok(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, base};
        hi = lo + (33'(words) << 2);
        a  = {1'b0, addr};
        if ((a < lo) || (a >= hi)) begin
            return ACC_RANGE;
        end
        if (addr[1:0] != 2'b00) begin
            return ACC_MISALIGNED;
        end
        return ACC_OK;
    endfunction

    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_array
// Description : WORDS x 32 synchronous RAM, per-byte write strobes and a
//               registered read port that holds its value between reads.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_index,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_index,
    output logic [31:0]   rd_data
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                r_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Only the read port register is reset; the storage itself is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= 32'h0000_0000;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_index];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/data_mem_be.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_be
// Description : Word-organised little-endian data memory with byte strobes,
//               configurable window/latency, ready/valid and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] FAULT_DATA = DEFAULT_FAULT_DATA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic        ready_o,
    output logic [31:0] read_data_o,
    output logic        rvalid_o,
    output logic        fault_o
);

    localparam int unsigned AW       = $clog2(WORD_COUNT);
    localparam int unsigned CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    logic          w_accept;
    acc_status_t   w_status;
    logic          w_valid;
    logic [AW-1:0] w_index;
    logic [3:0]    w_wr_be;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_write;
    logic             r_valid;
    logic [AW-1:0]    r_index;
    logic             r_fault_sel;

    logic          w_done;
    logic          w_done_write;
    logic          w_done_valid;
    logic [AW-1:0] w_done_index;
    logic          w_rd_en;
    logic [31:0]   w_array_rdata;

    assign w_accept = mem_req_i && ready_o;
    assign w_status = addr_ok(addr_i, BASE_ADDR, WORD_COUNT);
    assign w_valid  = (w_status == ACC_OK);
    assign w_index  = AW'(word_index(addr_i, BASE_ADDR));

    // Writes commit at the accept edge regardless of latency.
    assign w_wr_be = (w_accept && write_enable_i && w_valid) ? byte_enable_i : 4'b0000;

    // With LATENCY==1 the accept edge is also the completion edge, so the
    // live request drives completion; otherwise the captured request does.
    assign w_done       = (LATENCY == 1) ? w_accept
                                         : ((r_state == BUSY) && (r_cnt == CNT_W'(1)));
    assign w_done_write = (LATENCY == 1) ? write_enable_i : r_is_write;
    assign w_done_valid = (LATENCY == 1) ? w_valid        : r_valid;
    assign w_done_index = (LATENCY == 1) ? w_index        : r_index;

    assign w_rd_en = w_done && !w_done_write && w_done_valid;

    data_mem_array #(
        .WORDS (WORD_COUNT),
        .AW    (AW)
    ) u_array (
        .clk      (clk_i),
        .rst      (rst_i),
        .wr_be    (w_wr_be),
        .wr_index (w_index),
        .wr_data  (write_data_i),
        .rd_en    (w_rd_en),
        .rd_index (w_done_index),
        .rd_data  (w_array_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_valid     <= 1'b0;
            r_index     <= '0;
            r_fault_sel <= 1'b0;
            ready_o     <= 1'b1;
            rvalid_o    <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            rvalid_o <= w_done && !w_done_write;
            fault_o  <= w_done && !w_done_valid;
            if (w_done && !w_done_write) begin
                r_fault_sel <= !w_done_valid;
            end

            if (LATENCY > 1) begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_state    <= BUSY;
                            r_cnt      <= LAT_LOAD;
                            r_is_write <= write_enable_i;
                            r_valid    <= w_valid;
                            r_index    <= w_index;
                            ready_o    <= 1'b0;
                        end
                    end
                    BUSY: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= IDLE;
                            ready_o <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Both mux inputs are flops, so the output is stable for a full cycle.
    assign read_data_o = r_fault_sel ? FAULT_DATA : w_array_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_be
// Description : Directed, table-driven bench for data_mem_be at LATENCY 1
//               and LATENCY 3 (top-of-address-space window).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_be;

    logic        clk;
    logic        rst;

    logic        a_req, a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata;
    logic        a_ready, a_rvalid, a_fault;
    logic [31:0] a_rdata;

    logic        b_req, b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata;
    logic        b_ready, b_rvalid, b_fault;
    logic [31:0] b_rdata;

    int checks   = 0;
    int failures = 0;

    data_mem_be #(
        .WORD_COUNT (64),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (1),
        .FAULT_DATA (32'hfa11_1eaf)
    ) dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_req_i      (a_req),
        .write_enable_i (a_we),
        .byte_enable_i  (a_be),
        .addr_i         (a_addr),
        .write_data_i   (a_wdata),
        .ready_o        (a_ready),
        .read_data_o    (a_rdata),
        .rvalid_o       (a_rvalid),
        .fault_o        (a_fault)
    );

    data_mem_be #(
        .WORD_COUNT (16),
        .BASE_ADDR  (32'hFFFF_FFC0),
        .LATENCY    (3),
        .FAULT_DATA (32'hfa11_1eaf)
    ) dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_req_i      (b_req),
        .write_enable_i (b_we),
        .byte_enable_i  (b_be),
        .addr_i         (b_addr),
        .write_data_i   (b_wdata),
        .ready_o        (b_ready),
        .read_data_o    (b_rdata),
        .rvalid_o       (b_rvalid),
        .fault_o        (b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic        exp_fault;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One LATENCY=3 transaction: accept, two busy cycles, completion, idle.
    task automatic t3_op(input string nm, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic erv, input logic ef, input logic [31:0] ed);
        @(negedge clk);
        b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
        @(posedge clk); #1;
        chk({nm, " ready_e0"}, 32'(b_ready), 32'(1'b0));
        chk({nm, " rvalid_e0"}, 32'(b_rvalid), 32'(1'b0));
        @(negedge clk);
        b_req = 1'b0;
        @(posedge clk); #1;
        chk({nm, " ready_e1"}, 32'(b_ready), 32'(1'b0));
        @(posedge clk); #1;
        chk({nm, " rvalid_ec"}, 32'(b_rvalid), 32'(erv));
        chk({nm, " fault_ec"}, 32'(b_fault), 32'(ef));
        chk({nm, " rdata_ec"}, b_rdata, ed);
        chk({nm, " ready_ec"}, 32'(b_ready), 32'(1'b1));
        @(posedge clk); #1;
        chk({nm, " rvalid_after"}, 32'(b_rvalid), 32'(1'b0));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD};
        vecs[5]  = '{1'b0, 4'h0, 32'h0000_0022, 32'h0,         1'b1, 1'b1, 32'hFA11_1EAF};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 32'hFA11_1EAF};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_00FC, 32'h0102_0304, 1'b0, 1'b0, 32'hFA11_1EAF};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_0110, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFA11_1EAF};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0021, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFA11_1EAF};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0000_0000, 1'b0, 1'b0, 32'hFA11_1EAF};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 1'b0, 32'h11BB_33DD};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_00FC, 32'h0,         1'b1, 1'b0, 32'h0102_0304};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};

        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst a_ready",  32'(a_ready),  32'(1'b1));
        chk("rst a_rdata",  a_rdata,       32'h0);
        chk("rst a_rvalid", 32'(a_rvalid), 32'(1'b0));
        chk("rst a_fault",  32'(a_fault),  32'(1'b0));
        chk("rst b_ready",  32'(b_ready),  32'(1'b1));
        chk("rst b_rdata",  b_rdata,       32'h0);
        chk("rst b_rvalid", 32'(b_rvalid), 32'(1'b0));
        chk("rst b_fault",  32'(b_fault),  32'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // LATENCY=1: back-to-back vectors, one accept per cycle.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            a_req = 1'b1; a_we = vecs[i].we; a_be = vecs[i].be;
            a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
            @(posedge clk); #1;
            chk($sformatf("v%0d rvalid", i), 32'(a_rvalid), 32'(vecs[i].exp_rvalid));
            chk($sformatf("v%0d fault", i),  32'(a_fault),  32'(vecs[i].exp_fault));
            chk($sformatf("v%0d rdata", i),  a_rdata,       vecs[i].exp_rdata);
            chk($sformatf("v%0d ready", i),  32'(a_ready),  32'(1'b1));
        end
        @(negedge clk);
        a_req = 1'b0;
        @(posedge clk); #1;
        chk("a idle rvalid", 32'(a_rvalid), 32'(1'b0));

        // Mid-cycle reset clears registered outputs without a clock edge.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0010;
        @(posedge clk); #1;
        chk("pre-rst rvalid", 32'(a_rvalid), 32'(1'b1));
        a_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst rvalid", 32'(a_rvalid), 32'(1'b0));
        chk("midrst rdata",  a_rdata,       32'h0);
        chk("midrst ready",  32'(a_ready),  32'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        // Storage survives reset.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0020;
        @(posedge clk); #1;
        chk("post-rst a rdata",  a_rdata,       32'h11BB_33DD);
        chk("post-rst a rvalid", 32'(a_rvalid), 32'(1'b1));
        @(negedge clk);
        a_req = 1'b0;

        // LATENCY=3, window at the top of the 32-bit space.
        t3_op("b wr c0", 1'b1, 4'hF, 32'hFFFF_FFC0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        t3_op("b rd c0", 1'b0, 4'h0, 32'hFFFF_FFC0, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D);
        t3_op("b wr fc", 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hCAFE_F00D);
        t3_op("b rd fc", 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0, 32'h5A5A_5A5A);
        t3_op("b rd 00", 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 32'hFA11_1EAF);
        t3_op("b rd bc", 1'b0, 4'h0, 32'hFFFF_FFBC, 32'h0,         1'b1, 1'b1, 32'hFA11_1EAF);
        t3_op("b wr oor", 1'b1, 4'hF, 32'hFFFF_FF80, 32'h1234_5678, 1'b0, 1'b1, 32'hFA11_1EAF);

        // Requests held during BUSY are ignored: exactly one rvalid pulse.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'hFFFF_FFC0;
        @(posedge clk); #1;
        chk("busy ready e0", 32'(b_ready), 32'(1'b0));
        @(negedge clk);
        b_addr = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        chk("busy ready e1",  32'(b_ready),  32'(1'b0));
        chk("busy rvalid e1", 32'(b_rvalid), 32'(1'b0));
        @(posedge clk); #1;
        chk("busy rvalid ec", 32'(b_rvalid), 32'(1'b1));
        chk("busy rdata ec",  b_rdata,       32'hCAFE_F00D);
        chk("busy ready ec",  32'(b_ready),  32'(1'b1));
        @(negedge clk);
        b_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("busy no extra rvalid", 32'(b_rvalid), 32'(1'b0));
        end

        // Reset one cycle after a read accept drops the pending read.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'hFFFF_FFFC;
        @(posedge clk);
        @(negedge clk);
        b_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("b rst ready",  32'(b_ready),  32'(1'b1));
        chk("b rst rvalid", 32'(b_rvalid), 32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("b dropped rvalid", 32'(b_rvalid), 32'(1'b0));
            chk("b dropped fault",  32'(b_fault),  32'(1'b0));
            chk("b dropped ready",  32'(b_ready),  32'(1'b1));
        end
        t3_op("b rd c0 post", 1'b0, 4'h0, 32'hFFFF_FFC0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        t3_op("b rd fc post", 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 32'h5A5A_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_be.md
Name: data_mem_be

Overview:
- Parametrised successor of the core data memory.
- Word-organised, little-endian storage with per-byte write strobes, configurable base address and depth, and configurable read latency with a ready/valid handshake.
- Detects out-of-range and misaligned accesses and reports them instead of silently aliasing.
- Sits between the core's load/store unit and the data bus; the LSU stalls on ready_o.

Parameters:
- WORD_COUNT, 1024, number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*WORD_COUNT.
- LATENCY, 1, cycles from accept edge to data edge, inclusive; legal range 1..8.
- FAULT_DATA, 32'hfa11_1eaf, value returned on a faulting read.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_i  in  1  access request.
- write_enable_i  in  1  1 = write, 0 = read.
- byte_enable_i  in  4  write byte strobes; bit n covers write_data_i[8n+7:8n].
- addr_i  in  32  byte address.
- write_data_i  in  32  write data.
- ready_o  out  1  block can accept a request this cycle.
- read_data_o  out  32  registered read data.
- rvalid_o  out  1  one-cycle pulse: read_data_o updated.
- fault_o  out  1  one-cycle pulse at completion of a faulting access.

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: ready_o=1, read_data_o=0, rvalid_o=0, fault_o=0, FSM=IDLE, latency counter=0. Storage is not reset.
- Accept: mem_req_i && ready_o sampled at a rising edge (edge E0). Requests while ready_o=0 are ignored, not queued.
- Valid access: BASE_ADDR <= addr_i < BASE_ADDR+4*WORD_COUNT and addr_i[1:0]==0. Word index = (addr_i-BASE_ADDR)>>2.
- Write, valid: at E0, each byte lane with its strobe set takes the matching write_data_i byte; other lanes are unchanged. byte_enable_i=0 is a legal no-op. read_data_o is unchanged and rvalid_o stays low.
- Write, invalid: storage is unchanged; fault_o pulses at completion.
- Read: address and validity are captured at E0. At completion edge Ec = E0+(LATENCY-1):
  - read_data_o = stored word, or FAULT_DATA if the access is invalid.
  - rvalid_o pulses for one cycle.
  - fault_o pulses if the access is invalid.
  - byte_enable_i is ignored on reads.
- LATENCY==1: the FSM stays in IDLE and ready_o stays 1, so back-to-back accepts run every cycle.
- LATENCY>1, FSM states:
  - IDLE -> BUSY on accept; counter loaded with LATENCY-1. ready_o=0 from the cycle after E0.
  - BUSY: counter decrements each edge. When it reaches 0 at Ec: complete, go to IDLE, ready_o=1 in the following cycle.
- Ordering: a write commits at its own E0, so a later read of the same word returns the new data. A write while a read is BUSY cannot occur because ready_o=0.
- Reset mid-operation: the pending read is dropped and no rvalid_o/fault_o is produced. Writes already committed at E0 persist.
- Address arithmetic: 32-bit unsigned. BASE_ADDR+4*WORD_COUNT is computed in 33 bits so a top-of-space window does not wrap.

Decomposition:
- Package data_mem_pkg holds:
  - FAULT_DATA default.
  - state_t enum {IDLE, BUSY}.
  - Function addr_ok(addr, base, words), returning valid/misaligned/out-of-range.
- One sub-module, data_mem_array: a WORD_COUNT x 32 synchronous RAM with a 4-bit byte write enable and a registered read port. The top holds the FSM, counter, fault logic and output registers.

Test Plan:
- Reset then idle -> ready_o=1, read_data_o=0, rvalid_o=0, fault_o=0; rst_i asserted mid-cycle clears outputs without waiting for a clock edge.
- LATENCY=1, write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> next edge read_data_o=0xDEADBEEF, rvalid_o=1, ready_o held 1.
- Byte strobes: write 0x11223344 to 0x20 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read 0x20 -> read_data_o=0x11BB33DD.
- Faults: read 0x22 (misaligned), then read BASE_ADDR+4*WORD_COUNT -> each returns read_data_o=0xfa111eaf with fault_o=1. An out-of-range write leaves all words unchanged.
- LATENCY=3, read at E0 -> ready_o=0 for 2 cycles, data+rvalid_o at E0+2. A request presented while busy is ignored (no extra rvalid_o).
- LATENCY=3, rst_i asserted one cycle after a read accept -> no rvalid_o/fault_o pulse; ready_o=1 after reset; earlier writes still read back correctly.
